vga_axil_regfile: RTL

VGA_AXIL_REGFILE -- requirements
Module: vga_axil_regfile

---
 rtl/vga_axil_pkg.sv | 18 +
 rtl/vga_axil_wr_ctrl.sv | 82 ++++++++
 rtl/vga_axil_regfile.sv | 98 +++++++++
 3 files changed

// File: rtl/vga_axil_pkg.sv
// vga_axil_pkg: shared AXI-Lite types, write-FSM states and the byte-mask merge helper.
package vga_axil_pkg;
    typedef logic [31:0] axil_addr_t;
    typedef logic [31:0] axil_data_t;
    typedef logic [3:0]  axil_strb_t;
    typedef logic [1:0]  axil_resp_t;

    localparam axil_resp_t OKAY   = 2'b00;
    localparam axil_resp_t SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, GOT_AW, GOT_W, RESP} wr_state_e;

    function automatic axil_data_t strb_merge(axil_data_t old_d, axil_data_t new_d, axil_strb_t strb);
        axil_data_t m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = strb[b] ? new_d[8*b +: 8] : old_d[8*b +: 8];
        return m;
    endfunction
endpackage

// File: rtl/vga_axil_wr_ctrl.sv
// vga_axil_wr_ctrl: AXI-Lite write FSM with independent AW/W latches and a single commit strobe.
module vga_axil_wr_ctrl
    import vga_axil_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  axil_data_t        i_wdata,
    input  axil_strb_t        i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    output axil_resp_t        o_bresp,
    output logic              o_bvalid,
    input  logic              i_bready,
    output logic              o_we,
    output logic [IDX_W-1:0]  o_widx,
    output axil_data_t        o_wdata,
    output axil_strb_t        o_wstrb
);
    wr_state_e         r_state;
    wr_state_e         w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
    axil_data_t        r_data;
    axil_strb_t        r_strb;
    axil_resp_t        r_bresp;
    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_commit;
    logic              w_oor;
    logic              w_unused_lsb;

    assign o_awready    = (r_state == IDLE) || (r_state == GOT_W);
    assign o_wready     = (r_state == IDLE) || (r_state == GOT_AW);
    assign w_aw_hs      = i_awvalid && o_awready;
    assign w_w_hs       = i_wvalid && o_wready;
    // Bypass the latches when a handshake lands on the commit edge itself.
    assign w_addr       = w_aw_hs ? i_awaddr : r_addr;
    assign w_oor        = |w_addr[ADDR_W-1:IDX_W+2];
    assign w_commit     = (r_state != RESP) && (w_next == RESP);
    assign w_unused_lsb = ^w_addr[1:0];
    assign o_we         = w_commit && !w_oor;
    assign o_widx       = w_addr[IDX_W+1:2];
    assign o_wdata      = w_w_hs ? i_wdata : r_data;
    assign o_wstrb      = w_w_hs ? i_wstrb : r_strb;
    assign o_bvalid     = r_state == RESP;
    assign o_bresp      = r_bresp;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_aw_hs && w_w_hs) ? RESP : w_aw_hs ? GOT_AW : w_w_hs ? GOT_W : IDLE;
            GOT_AW:  w_next = w_w_hs ? RESP : GOT_AW;
            GOT_W:   w_next = w_aw_hs ? RESP : GOT_W;
            RESP:    w_next = i_bready ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_data  <= '0;
            r_strb  <= '0;
            r_bresp <= OKAY;
        end else begin
            r_state <= w_next;
            if (w_aw_hs) r_addr <= i_awaddr;
            if (w_w_hs) begin
                r_data <= i_wdata;
                r_strb <= i_wstrb;
            end
            if (w_commit) r_bresp <= w_oor ? SLVERR : OKAY;
        end
    end
endmodule

// File: rtl/vga_axil_regfile.sv
// vga_axil_regfile: AXI-Lite slave exposing NUM_REGS 32-bit VGA configuration registers.
module vga_axil_regfile
    import vga_axil_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 32
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [ADDR_W-1:0]      awaddr,
    input  logic                   awvalid,
    output logic                   awready,
    input  axil_data_t             wdata,
    input  axil_strb_t             wstrb,
    input  logic                   wvalid,
    output logic                   wready,
    output axil_resp_t             bresp,
    output logic                   bvalid,
    input  logic                   bready,
    input  logic [ADDR_W-1:0]      araddr,
    input  logic                   arvalid,
    output logic                   arready,
    output axil_data_t             rdata,
    output axil_resp_t             rresp,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [NUM_REGS*32-1:0] regs_o
);
    localparam int IDX_W = $clog2(NUM_REGS);

    axil_data_t       r_regs [NUM_REGS];
    logic             w_we;
    logic [IDX_W-1:0] w_widx;
    axil_data_t       w_wd;
    axil_strb_t       w_ws;
    logic             r_rvalid;
    axil_data_t       r_rdata;
    axil_resp_t       r_rresp;
    logic             w_ar_hs;
    logic             w_r_oor;
    logic [IDX_W-1:0] w_ridx;
    logic             w_unused_lsb;

    vga_axil_wr_ctrl #(.ADDR_W(ADDR_W), .IDX_W(IDX_W)) u_wr_ctrl (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_awaddr  (awaddr),
        .i_awvalid (awvalid),
        .o_awready (awready),
        .i_wdata   (wdata),
        .i_wstrb   (wstrb),
        .i_wvalid  (wvalid),
        .o_wready  (wready),
        .o_bresp   (bresp),
        .o_bvalid  (bvalid),
        .i_bready  (bready),
        .o_we      (w_we),
        .o_widx    (w_widx),
        .o_wdata   (w_wd),
        .o_wstrb   (w_ws)
    );

    assign arready      = !r_rvalid;
    assign w_ar_hs      = arvalid && arready;
    assign w_r_oor      = |araddr[ADDR_W-1:IDX_W+2];
    assign w_ridx       = araddr[IDX_W+1:2];
    assign w_unused_lsb = ^araddr[1:0];
    assign rvalid       = r_rvalid;
    assign rdata        = r_rdata;
    assign rresp        = r_rresp;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
        end else if (w_we) begin
            r_regs[w_widx] <= strb_merge(r_regs[w_widx], w_wd, w_ws);
        end
    end

    // Non-blocking sample means a same-edge write is seen by the read as the old value.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_r_oor ? '0 : r_regs[w_ridx];
            r_rresp  <= w_r_oor ? SLVERR : OKAY;
        end else if (r_rvalid && rready) begin
            r_rvalid <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        assign regs_o[32*i +: 32] = r_regs[i];
    end
endmodule
